// File: rtl/bsg_axil_txs_packer_pkg.sv
// Shared link-to-AXIL definitions for the transmit-side packer.
//   txs_pack_state_e  : assembler FSM states
//   drop_cnt_width_lp : width of the saturating dropped-word counter
package bsg_axil_txs_packer_pkg;

   typedef enum logic [0:0] {
      E_PK_COLLECT = 1'b0,
      E_PK_SEND    = 1'b1
   } txs_pack_state_e;

   localparam int unsigned drop_cnt_width_lp = 16;

endpackage

// File: rtl/bsg_axil_txs_packer_if.sv
// Word-in / packet-out link bundle of the transmit packer.
//   tx, tx_v   : 32-bit word stream from the write decoder (valid only, no backpressure)
//   pkt, pkt_v : assembled packet toward the manycore link endpoint, word 0 in bits [31:0]
//   pkt_ready  : endpoint accepts the packet
// master = decoder/endpoint side, slave = packer side.
// words_per_pkt_p must match the packer instance it connects to.
interface bsg_axil_txs_packer_if #(
   parameter int unsigned words_per_pkt_p = 4
) ();

   logic [31:0]                   tx;
   logic                          tx_v;
   logic [32*words_per_pkt_p-1:0] pkt;
   logic                          pkt_v;
   logic                          pkt_ready;

   modport master (output tx, tx_v, pkt_ready, input  pkt, pkt_v);
   modport slave  (input  tx, tx_v, pkt_ready, output pkt, pkt_v);

endinterface

// File: rtl/bsg_axil_txs_word_fifo.sv
// Ring-buffer word FIFO for the transmit packer.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   data_i, v_i      : incoming word; dropped when the FIFO is full
//   yumi_i           : pop the head word (ignored when empty)
//   data_o           : head word
//   count_o          : registered occupancy (0..els_p)
//   drop_o           : a word was offered while full this cycle
module bsg_axil_txs_word_fifo #(
   parameter  int unsigned els_p    = 16,
   localparam int unsigned ptr_w_lp = $clog2(els_p),
   localparam int unsigned cnt_w_lp = $clog2(els_p + 1)
) (
   input  logic                clk_i,
   input  logic                reset_n_i,
   input  logic [31:0]         data_i,
   input  logic                v_i,
   input  logic                yumi_i,
   output logic [31:0]         data_o,
   output logic [cnt_w_lp-1:0] count_o,
   output logic                drop_o
);

   logic [31:0]         mem_q [els_p];
   // Extra MSB is the wrap bit; the pointers roll over naturally at 2*els_p.
   logic [ptr_w_lp:0]   wr_ptr_q, wr_ptr_d;
   logic [ptr_w_lp:0]   rd_ptr_q, rd_ptr_d;
   logic [cnt_w_lp-1:0] count_q, count_d;
   logic                full, empty, push, pop;

   assign full  = (count_q == cnt_w_lp'(els_p));
   assign empty = (count_q == '0);
   // Full is judged on the pre-edge count, so a same-cycle pop does not rescue a push.
   assign push  = v_i & ~full;
   assign pop   = yumi_i & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: a location is only read after it has been written.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q[ptr_w_lp-1:0]] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q[ptr_w_lp-1:0]];
   assign count_o = count_q;
   assign drop_o  = v_i & full;

endmodule

// File: rtl/bsg_axil_txs_packer.sv
// Per-slot transmit packet assembler.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   link (slave)     : word input (tx/tx_v) and packet output (pkt/pkt_v/pkt_ready)
//   clr_isr_txc_i    : one-cycle pulse clearing the TXC bit
//   vacancy_o        : free word FIFO entries (TDFV)
//   isr_txc_o        : sticky tx-complete, set by each packet handshake
//   ovf_o            : sticky overflow, cleared only by reset
//   drop_cnt_o       : saturating count of words dropped on a full FIFO
// Every words_per_pkt_p words become one packet; word 0 is the earliest received.
module bsg_axil_txs_packer
   import bsg_axil_txs_packer_pkg::*;
#(
   parameter  int unsigned words_per_pkt_p = 4,
   parameter  int unsigned fifo_els_p      = 16,
   localparam int unsigned cnt_w_lp        = $clog2(fifo_els_p + 1),
   localparam int unsigned idx_w_lp        = $clog2(words_per_pkt_p)
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   bsg_axil_txs_packer_if.slave         link,
   input  logic                         clr_isr_txc_i,
   output logic [cnt_w_lp-1:0]          vacancy_o,
   output logic                         isr_txc_o,
   output logic                         ovf_o,
   output logic [drop_cnt_width_lp-1:0] drop_cnt_o
);

   logic [31:0]         head;
   logic [cnt_w_lp-1:0] count;
   logic                drop, pop, txc_set;

   bsg_axil_txs_word_fifo #(
      .els_p (fifo_els_p)
   ) u_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .data_i    (link.tx),
      .v_i       (link.tx_v),
      .yumi_i    (pop),
      .data_o    (head),
      .count_o   (count),
      .drop_o    (drop)
   );

   txs_pack_state_e                state_q, state_d;
   logic [idx_w_lp-1:0]            idx_q, idx_d;
   logic [32*words_per_pkt_p-1:0]  pkt_q, pkt_d;
   logic                           txc_q, txc_d;
   logic                           ovf_q, ovf_d;
   logic [drop_cnt_width_lp-1:0]   drop_cnt_q, drop_cnt_d;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      pkt_d      = pkt_q;
      pop        = 1'b0;
      txc_set    = 1'b0;
      link.pkt_v = 1'b0;
      case (state_q)
         E_PK_COLLECT: begin
            if (count != '0) begin
               pop                  = 1'b1;
               pkt_d[idx_q*32 +: 32] = head;
               if (idx_q == idx_w_lp'(words_per_pkt_p - 1)) begin
                  idx_d   = '0;
                  state_d = E_PK_SEND;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         E_PK_SEND: begin
            link.pkt_v = 1'b1;
            if (link.pkt_ready) begin
               state_d = E_PK_COLLECT;
               txc_set = 1'b1;
            end
         end
         default: state_d = E_PK_COLLECT;
      endcase
   end

   always_comb begin
      // Set wins over a coincident clear.
      txc_d      = txc_set | (txc_q & ~clr_isr_txc_i);
      ovf_d      = ovf_q | drop;
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= E_PK_COLLECT;
         idx_q      <= '0;
         pkt_q      <= '0;
         txc_q      <= 1'b0;
         ovf_q      <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         pkt_q      <= pkt_d;
         txc_q      <= txc_d;
         ovf_q      <= ovf_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign link.pkt   = pkt_q;
   assign vacancy_o  = cnt_w_lp'(fifo_els_p) - count;
   assign isr_txc_o  = txc_q;
   assign ovf_o      = ovf_q;
   assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_bsg_axil_txs_packer.sv
// Directed bench for bsg_axil_txs_packer (4 words/packet, 16-entry FIFO).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_bsg_axil_txs_packer;

   localparam int unsigned words_lp = 4;
   localparam int unsigned els_lp   = 16;

   logic        clk_i = 1'b0;
   logic        reset_n_i;
   logic        clr_isr_txc_i;
   logic [4:0]  vacancy_o;
   logic        isr_txc_o;
   logic        ovf_o;
   logic [15:0] drop_cnt_o;

   int unsigned pass_cnt = 0;
   int unsigned chk_cnt  = 0;

   bsg_axil_txs_packer_if #(.words_per_pkt_p(words_lp)) link ();

   bsg_axil_txs_packer #(
      .words_per_pkt_p (words_lp),
      .fifo_els_p      (els_lp)
   ) dut (
      .clk_i         (clk_i),
      .reset_n_i     (reset_n_i),
      .link          (link),
      .clr_isr_txc_i (clr_isr_txc_i),
      .vacancy_o     (vacancy_o),
      .isr_txc_o     (isr_txc_o),
      .ovf_o         (ovf_o),
      .drop_cnt_o    (drop_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic [31:0] w);
      link.tx   = w;
      link.tx_v = 1'b1;
      tick();
   endtask

   // Packet of four consecutive word values starting at first.
   function automatic logic [127:0] seq_pkt(input logic [31:0] first);
      logic [127:0] p;
      for (int k = 0; k < 4; k++) p[32*k +: 32] = first + 32'(k);
      return p;
   endfunction

   initial begin
      int p;
      reset_n_i        = 1'b0;
      clr_isr_txc_i    = 1'b0;
      link.tx          = '0;
      link.tx_v        = 1'b0;
      link.pkt_ready   = 1'b0;

      // Reset values
      #12;
      check("rst_pkt_v", link.pkt_v, 1'b0);
      check("rst_vacancy", vacancy_o, 5'd16);
      check("rst_pkt", link.pkt, 128'h0);
      check("rst_txc", isr_txc_o, 1'b0);
      check("rst_ovf", ovf_o, 1'b0);
      check("rst_drop", drop_cnt_o, 16'h0);
      reset_n_i = 1'b1;
      tick();

      // 1: single packet, ready held high
      link.pkt_ready = 1'b1;
      push(32'h11); push(32'h22); push(32'h33); push(32'h44);
      link.tx_v = 1'b0;
      check("t1_pkt_v_early", link.pkt_v, 1'b0);
      tick();
      check("t1_pkt_v", link.pkt_v, 1'b1);
      check("t1_pkt", link.pkt, 128'h00000044_00000033_00000022_00000011);
      tick();
      check("t1_pkt_v_one_cycle", link.pkt_v, 1'b0);
      check("t1_txc", isr_txc_o, 1'b1);
      check("t1_vacancy", vacancy_o, 5'd16);

      // 2: overflow with ready low; 4 words sit in the packet, 16 in the FIFO, 4 dropped
      link.pkt_ready = 1'b0;
      for (int i = 0; i < 24; i++) push(32'h100 + 32'(i));
      link.tx_v = 1'b0;
      check("t2_drop", drop_cnt_o, 16'd4);
      check("t2_ovf", ovf_o, 1'b1);
      check("t2_vacancy_full", vacancy_o, 5'd0);
      check("t2_pkt_v_held", link.pkt_v, 1'b1);
      link.pkt_ready = 1'b1;
      p = 0;
      for (int c = 0; c < 60 && p < 5; c++) begin
         if (link.pkt_v) begin
            check("t2_pkt", link.pkt, seq_pkt(32'h100 + 32'(4*p)));
            p++;
         end
         tick();
      end
      link.pkt_ready = 1'b0;
      check("t2_npkts", p, 5);
      check("t2_vacancy_drained", vacancy_o, 5'd16);
      check("t2_ovf_sticky", ovf_o, 1'b1);

      // 3: TXC clear alone, then clear coincident with a handshake
      clr_isr_txc_i = 1'b1; tick(); clr_isr_txc_i = 1'b0;
      check("t3_lone_clr", isr_txc_o, 1'b0);
      push(32'hA0); push(32'hA1); push(32'hA2); push(32'hA3);
      link.tx_v = 1'b0;
      tick();
      check("t3_pkt_v", link.pkt_v, 1'b1);
      tick(); tick();
      check("t3_pkt_v_stable", link.pkt_v, 1'b1);
      check("t3_pkt_stable", link.pkt, seq_pkt(32'hA0));
      link.pkt_ready = 1'b1;
      clr_isr_txc_i  = 1'b1;
      tick();
      link.pkt_ready = 1'b0;
      clr_isr_txc_i  = 1'b0;
      check("t3_set_wins", isr_txc_o, 1'b1);
      check("t3_pkt_v_done", link.pkt_v, 1'b0);
      clr_isr_txc_i = 1'b1; tick(); clr_isr_txc_i = 1'b0;
      check("t3_later_clr", isr_txc_o, 1'b0);

      // 4: asynchronous reset mid-packet
      push(32'hB0); push(32'hB1);
      link.tx_v = 1'b0;
      tick();
      #3 reset_n_i = 1'b0;
      #1;
      check("t4_pkt_v", link.pkt_v, 1'b0);
      check("t4_vacancy", vacancy_o, 5'd16);
      check("t4_pkt", link.pkt, 128'h0);
      check("t4_ovf", ovf_o, 1'b0);
      check("t4_drop", drop_cnt_o, 16'h0);
      #10 reset_n_i = 1'b1;
      tick();
      link.pkt_ready = 1'b1;
      push(32'hC0); push(32'hC1); push(32'hC2); push(32'hC3);
      link.tx_v = 1'b0;
      tick();
      check("t4_new_pkt_v", link.pkt_v, 1'b1);
      check("t4_new_pkt", link.pkt, seq_pkt(32'hC0));
      tick();
      check("t4_txc", isr_txc_o, 1'b1);

      // 5: continuous stream of 64 words, pointers wrap, no drops
      p = 0;
      for (int c = 0; c < 120; c++) begin
         if (link.pkt_v) begin
            check("t5_pkt", link.pkt, seq_pkt(32'h1000 + 32'(4*p)));
            p++;
         end
         link.tx   = 32'h1000 + 32'(c);
         link.tx_v = (c < 64);
         tick();
      end
      link.tx_v = 1'b0;
      check("t5_npkts", p, 16);
      check("t5_drop", drop_cnt_o, 16'h0);
      check("t5_ovf", ovf_o, 1'b0);
      check("t5_vacancy", vacancy_o, 5'd16);

      // 6: drop counter saturation (20 words fill packet + FIFO, the rest drop)
      link.pkt_ready = 1'b0;
      for (int i = 0; i < 20 + 65534; i++) push(32'(i));
      check("t6_drop_fffe", drop_cnt_o, 16'hFFFE);
      push(32'h0);
      check("t6_drop_ffff", drop_cnt_o, 16'hFFFF);
      for (int i = 0; i < 5; i++) push(32'h0);
      link.tx_v = 1'b0;
      check("t6_drop_sat", drop_cnt_o, 16'hFFFF);
      check("t6_ovf", ovf_o, 1'b1);
      check("t6_vacancy", vacancy_o, 5'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
